// File: rtl/core_bus_arbiter.sv
// Core-to-core instruction bus server: round-robin arbitration among senders,
// then a one-cycle registered delivery to one core or to every other core.
module core_bus_arbiter #(
  parameter  int NUM_CORES     = 4,
  parameter  int INSTR_WIDTH   = 2,
  localparam int CORE_ID_WIDTH = $clog2(NUM_CORES)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_CORES-1:0]                 send_req,
  input  logic [NUM_CORES-1:0]                 broadcast_mode,
  input  logic [NUM_CORES*CORE_ID_WIDTH-1:0]   dst_ids,
  input  logic [NUM_CORES*INSTR_WIDTH-1:0]     instructions,
  output logic [NUM_CORES-1:0]                 send_grant,
  output logic [NUM_CORES-1:0]                 recv_valid,
  output logic [CORE_ID_WIDTH-1:0]             src_id,
  output logic [INSTR_WIDTH-1:0]               instruction,
  output logic                                 busy,
  output logic                                 dropped
);

  typedef enum logic {ARB, DELIVER} state_t;

  typedef struct packed {
    logic [CORE_ID_WIDTH-1:0] win;
    logic                     bcast;
    logic [CORE_ID_WIDTH-1:0] dst;
    logic [INSTR_WIDTH-1:0]   instr;
  } sel_t;

  state_t                   state;
  logic [CORE_ID_WIDTH-1:0] rr_ptr;
  sel_t                     sel;
  logic                     found;
  logic [NUM_CORES-1:0]     grant_nxt;
  logic [NUM_CORES-1:0]     recv_nxt;
  logic                     drop_nxt;

  // First requester at or after rr_ptr, wrapping modulo NUM_CORES.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (!found && send_req[(int'(rr_ptr) + k) % NUM_CORES]) begin
        found   = 1'b1;
        sel.win = CORE_ID_WIDTH'((int'(rr_ptr) + k) % NUM_CORES);
      end
    end
    sel.bcast = broadcast_mode[sel.win];
    sel.dst   = dst_ids[int'(sel.win)*CORE_ID_WIDTH +: CORE_ID_WIDTH];
    sel.instr = instructions[int'(sel.win)*INSTR_WIDTH +: INSTR_WIDTH];
  end

  // Out-of-range unicast destinations match no lane, so recv_nxt is all zero.
  for (genvar i = 0; i < NUM_CORES; i++) begin : g_lane
    assign grant_nxt[i] = (sel.win == CORE_ID_WIDTH'(i));
    assign recv_nxt[i]  = sel.bcast ? (sel.win != CORE_ID_WIDTH'(i))
                                    : (sel.dst == CORE_ID_WIDTH'(i));
  end

  assign drop_nxt = !sel.bcast && (int'(sel.dst) >= NUM_CORES);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ARB;
      rr_ptr      <= '0;
      send_grant  <= '0;
      recv_valid  <= '0;
      src_id      <= '0;
      instruction <= '0;
      busy        <= 1'b0;
      dropped     <= 1'b0;
    end else begin
      case (state)
        ARB: begin
          if (|send_req) begin
            state       <= DELIVER;
            send_grant  <= grant_nxt;
            recv_valid  <= recv_nxt;
            src_id      <= sel.win;
            instruction <= sel.instr;
            busy        <= 1'b1;
            dropped     <= drop_nxt;
            rr_ptr      <= CORE_ID_WIDTH'((int'(sel.win) + 1) % NUM_CORES);
          end
        end
        DELIVER: begin
          // src_id / instruction keep their last values.
          state      <= ARB;
          send_grant <= '0;
          recv_valid <= '0;
          busy       <= 1'b0;
          dropped    <= 1'b0;
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Scoreboard bench: a 4-core and a 3-core arbiter driven by directed requests,
// checked by a negedge monitor against hand-computed deliveries.
module tb_core_bus_arbiter;

  typedef struct {
    int         cyc;
    logic [3:0] grant;
    logic [3:0] recv;
    logic [1:0] src;
    logic [1:0] instr;
    logic       drop;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0] req_a = '0, bc_a = '0;
  logic [7:0] dst_a = '0, ins_a = '0;
  logic [3:0] grant_a, recv_a;
  logic [1:0] src_a, instr_a;
  logic       busy_a, drop_a;

  logic [2:0] req_b = '0, bc_b = '0;
  logic [5:0] dst_b = '0, ins_b = '0;
  logic [2:0] grant_b, recv_b;
  logic [1:0] src_b, instr_b;
  logic       busy_b, drop_b;

  core_bus_arbiter #(.NUM_CORES(4), .INSTR_WIDTH(2)) dut_a (
    .clk(clk), .rst(rst), .send_req(req_a), .broadcast_mode(bc_a),
    .dst_ids(dst_a), .instructions(ins_a), .send_grant(grant_a),
    .recv_valid(recv_a), .src_id(src_a), .instruction(instr_a),
    .busy(busy_a), .dropped(drop_a));

  core_bus_arbiter #(.NUM_CORES(3), .INSTR_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst), .send_req(req_b), .broadcast_mode(bc_b),
    .dst_ids(dst_b), .instructions(ins_b), .send_grant(grant_b),
    .recv_valid(recv_b), .src_id(src_b), .instruction(instr_b),
    .busy(busy_b), .dropped(drop_b));

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks = 0;
  int   errors = 0;
  logic done = 1'b0;
  logic fin  = 1'b0;

  // ---------------- monitor ----------------
  task automatic cmp(input string nm, input exp_t e, input int c,
                     input logic [3:0] g, input logic [3:0] r,
                     input logic [1:0] s, input logic [1:0] i, input logic d);
    checks++;
    if (c !== e.cyc || g !== e.grant || r !== e.recv || s !== e.src ||
        i !== e.instr || d !== e.drop) begin
      errors++;
      $display("FAIL %s: got cyc=%0d grant=%b recv=%b src=%0d instr=%b drop=%b, want cyc=%0d grant=%b recv=%b src=%0d instr=%b drop=%b",
               nm, c, g, r, s, i, d, e.cyc, e.grant, e.recv, e.src, e.instr, e.drop);
    end
  endtask

  logic prev_a = 1'b0, prev_b = 1'b0, rst_d = 1'b0;
  exp_t e;

  always @(negedge clk) begin
    if (rst_d) begin
      checks++;
      if ({grant_a, recv_a, src_a, instr_a, busy_a, drop_a} !== '0 ||
          {grant_b, recv_b, src_b, instr_b, busy_b, drop_b} !== '0) begin
        errors++;
        $display("FAIL reset_state: a=%b_%b_%0d_%b_%b_%b b=%b_%b_%0d_%b_%b_%b, want all zero",
                 grant_a, recv_a, src_a, instr_a, busy_a, drop_a,
                 grant_b, recv_b, src_b, instr_b, busy_b, drop_b);
      end
    end
    rst_d = rst;

    if (busy_a) begin
      checks++;
      if (prev_a) begin errors++; $display("FAIL a_spacing: busy high 2 cycles running at cyc=%0d, want 1", cyc); end
      if (q_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected: delivery grant=%b at cyc=%0d, want none", grant_a, cyc);
      end else begin
        e = q_a.pop_front();
        cmp("a_deliver", e, cyc, grant_a, recv_a, src_a, instr_a, drop_a);
      end
    end else begin
      checks++;
      if (grant_a !== '0 || recv_a !== '0 || drop_a !== 1'b0) begin
        errors++;
        $display("FAIL a_idle: grant=%b recv=%b drop=%b at cyc=%0d, want 0", grant_a, recv_a, drop_a, cyc);
      end
    end
    prev_a = busy_a;

    if (busy_b) begin
      checks++;
      if (prev_b) begin errors++; $display("FAIL b_spacing: busy high 2 cycles running at cyc=%0d, want 1", cyc); end
      if (q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected: delivery grant=%b at cyc=%0d, want none", grant_b, cyc);
      end else begin
        e = q_b.pop_front();
        cmp("b_deliver", e, cyc, {1'b0, grant_b}, {1'b0, recv_b}, src_b, instr_b, drop_b);
      end
    end else begin
      checks++;
      if (grant_b !== '0 || recv_b !== '0 || drop_b !== 1'b0) begin
        errors++;
        $display("FAIL b_idle: grant=%b recv=%b drop=%b at cyc=%0d, want 0", grant_b, recv_b, drop_b, cyc);
      end
    end
    prev_b = busy_b;

    if (done && !fin) begin
      checks++;
      if (q_a.size() != 0 || q_b.size() != 0) begin
        errors++;
        $display("FAIL missing_delivery: pending a=%0d b=%0d, want 0 0", q_a.size(), q_b.size());
      end
      fin = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
    req_a = req_a & ~grant_a;
    req_b = req_b & ~grant_b;
  endtask

  task automatic exp_a(input int c, input logic [3:0] g, input logic [3:0] r,
                       input logic [1:0] s, input logic [1:0] i, input logic d);
    q_a.push_back('{c, g, r, s, i, d});
  endtask

  task automatic exp_b(input int c, input logic [3:0] g, input logic [3:0] r,
                       input logic [1:0] s, input logic [1:0] i, input logic d);
    q_b.push_back('{c, g, r, s, i, d});
  endtask

  task automatic load_a(input int core, input logic bc, input logic [1:0] d, input logic [1:0] ins);
    bc_a[core] = bc;
    dst_a[core*2 +: 2] = d;
    ins_a[core*2 +: 2] = ins;
  endtask

  task automatic load_b(input int core, input logic bc, input logic [1:0] d, input logic [1:0] ins);
    bc_b[core] = bc;
    dst_b[core*2 +: 2] = d;
    ins_b[core*2 +: 2] = ins;
  endtask

  int c;

  initial begin
    step(); step();
    rst = 1'b0;
    repeat (10) step();

    // unicast core 2 -> core 1
    load_a(2, 1'b0, 2'd1, 2'b10); req_a[2] = 1'b1;
    exp_a(cyc + 1, 4'b0100, 4'b0010, 2'd2, 2'b10, 1'b0);
    repeat (3) step();

    // broadcast from core 0 (rr_ptr now 3, wraps to 0)
    load_a(0, 1'b1, 2'd2, 2'b01); req_a[0] = 1'b1;
    exp_a(cyc + 1, 4'b0001, 4'b1110, 2'd0, 2'b01, 1'b0);
    repeat (3) step();

    // core 3 sends to itself
    load_a(3, 1'b0, 2'd3, 2'b11); req_a[3] = 1'b1;
    exp_a(cyc + 1, 4'b1000, 4'b1000, 2'd3, 2'b11, 1'b0);
    repeat (3) step();

    // full contention, rr_ptr = 0; core k sends instr k to core k+1
    load_a(0, 1'b0, 2'd1, 2'd0);
    load_a(1, 1'b0, 2'd2, 2'd1);
    load_a(2, 1'b0, 2'd3, 2'd2);
    load_a(3, 1'b0, 2'd0, 2'd3);
    c = cyc; req_a = 4'b1111;
    exp_a(c + 1, 4'b0001, 4'b0010, 2'd0, 2'd0, 1'b0);
    exp_a(c + 3, 4'b0010, 4'b0100, 2'd1, 2'd1, 1'b0);
    exp_a(c + 5, 4'b0100, 4'b1000, 2'd2, 2'd2, 1'b0);
    exp_a(c + 7, 4'b1000, 4'b0001, 2'd3, 2'd3, 1'b0);
    repeat (9) step();

    // second round starts at core 0 again
    c = cyc; req_a = 4'b1011;
    exp_a(c + 1, 4'b0001, 4'b0010, 2'd0, 2'd0, 1'b0);
    exp_a(c + 3, 4'b0010, 4'b0100, 2'd1, 2'd1, 1'b0);
    exp_a(c + 5, 4'b1000, 4'b0001, 2'd3, 2'd3, 1'b0);
    repeat (7) step();

    // reset during DELIVER; afterwards search restarts from core 0
    c = cyc; req_a = 4'b0110;
    exp_a(c + 1, 4'b0010, 4'b0100, 2'd1, 2'd1, 1'b0);
    step();
    rst = 1'b1;
    step();
    req_a = 4'b0000;
    rst = 1'b0;
    c = cyc; req_a = 4'b1010;
    exp_a(c + 1, 4'b0010, 4'b0100, 2'd1, 2'd1, 1'b0);
    exp_a(c + 3, 4'b1000, 4'b0001, 2'd3, 2'd3, 1'b0);
    repeat (6) step();

    // 3-core bus: out-of-range destination is dropped but still granted
    load_b(1, 1'b0, 2'd3, 2'b11); req_b[1] = 1'b1;
    exp_b(cyc + 1, 4'b0010, 4'b0000, 2'd1, 2'b11, 1'b1);
    repeat (3) step();

    load_b(2, 1'b0, 2'd0, 2'b01); req_b[2] = 1'b1;
    exp_b(cyc + 1, 4'b0100, 4'b0001, 2'd2, 2'b01, 1'b0);
    repeat (3) step();

    // broadcast ignores dst even when out of range
    load_b(0, 1'b1, 2'd3, 2'b10); req_b[0] = 1'b1;
    exp_b(cyc + 1, 4'b0001, 4'b0110, 2'd0, 2'b10, 1'b0);
    repeat (3) step();

    done = 1'b1;
    for (int i = 0; i < 20 && !fin; i++) @(posedge clk);
    if (!fin) begin
      $display("FAIL final_check: monitor did not finish, want finished");
      $fatal(1, "monitor timeout");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
